dmem_host_sequencer: RTL and testbench
======================================

Name: dmem_host_sequencer

Overview:
- Host-side sequencer that sits directly upstream of the matrix-multiply top level and drives its testbench-facing pins.
- Streams operand words from a valid/ready source into data memory, then pulses START, then waits for END.
- Reads the result region back out of data memory and presents it on a valid/ready stream.
- Replaces hand-written testbench memory loading and lets the top level run from an FPGA host link.

Parameters:
- DATA_W, 16, data memory word width
- ADDR_W, 16, data memory address width
- TIMEOUT, 65535, maximum cycles in RUN before the error exit

Ports:
- clk  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- cmd_go  in  1  one-cycle job start; ignored unless in IDLE, DONE or ERR
- load_base  in  ADDR_W  first data memory address to load
- load_len  in  ADDR_W  number of words to load
- res_base  in  ADDR_W  first result address
- res_len  in  ADDR_W  number of result words to read back
- in_valid  in  1  operand word valid
- in_data  in  DATA_W  operand word
- in_ready  out  1  operand word accepted
- current_addr  out  ADDR_W  write address to top
- write_from_tb  out  1  data memory write enable to top
- mem_data  out  DATA_W  write data to top
- addr_mux_select  out  2  00 core, 01 host write, 10 host read
- ar_in  out  ADDR_W  read address to top
- START  out  1  core start pulse
- core_end  in  1  END from top
- rd_data  in  DATA_W  data memory output (dmem_out_disp)
- out_valid  out  1  result word valid
- out_data  out  DATA_W  result word
- out_ready  in  1  result sink ready
- busy  out  1  high in any state except IDLE, DONE, ERR
- done  out  1  high in DONE
- timeout_err  out  1  high in ERR

Behaviour:
- Reset: state IDLE. All outputs 0, addr_mux_select=00, counters 0. Reset is asynchronous at any time, including mid-job.
- IDLE/DONE/ERR + cmd_go: latch all four base/len inputs and clear the pointers.
  - load_len=0: go to KICK.
  - Otherwise: go to LOAD.
- LOAD:
  - addr_mux_select=01; in_ready=1.
  - On in_valid&&in_ready, in the same cycle: write_from_tb=1, current_addr=load_base+idx (mod 2^ADDR_W), mem_data=in_data, idx++.
  - After the last word (idx==load_len-1 accepted): go to KICK.
  - write_from_tb is 0 in every cycle without a handshake.
  - in_ready is 0 in all other states.
- KICK:
  - addr_mux_select=00; START=1 for exactly one cycle.
  - Sample core_end into end_q, then go to RUN.
- RUN:
  - addr_mux_select=00.
  - Wait for a rising edge of core_end (core_end=1 and end_q=0; end_q updated every cycle). A stale high END from a previous job is ignored.
  - On the edge: res_len=0 goes to DONE, otherwise go to RD_ADDR.
  - The cycle counter increments each RUN cycle. When it reaches TIMEOUT with no edge, go to ERR.
  - An edge and the timeout in the same cycle: the edge wins.
- RD_ADDR:
  - addr_mux_select=10; ar_in=res_base+ridx.
  - Go to RD_CAP next cycle (one-cycle synchronous read latency).
- RD_CAP:
  - Hold addr_mux_select and ar_in; register out_data=rd_data; out_valid=1.
  - Go to OUT.
- OUT:
  - Hold out_valid and out_data stable until out_ready.
  - On out_valid&&out_ready: out_valid=0, ridx++.
  - Last word: go to DONE. Otherwise go to RD_ADDR.
  - Throughput is 1 word per 3 cycles minimum.
- DONE: done=1 until cmd_go or reset.
- ERR: timeout_err=1 until cmd_go or reset.
- cmd_go while busy: ignored; no latched field changes.
- Address arithmetic wraps modulo 2^ADDR_W.
- START is never asserted outside KICK.

Test Plan:
- load_base=0x0010, load_len=4, data A1,B2,C3,D4 with in_valid always high -> four consecutive write_from_tb cycles at 0x10..0x13; then exactly one START pulse.
- Source drops in_valid every other cycle -> writes occur only on handshake cycles; current_addr still increments 0x10..0x13 with no gaps or duplicates.
- core_end held high before cmd_go, then dropped, then raised 20 cycles after START -> RUN exits only on that rising edge, not on the stale high.
- res_base=0x0040, res_len=3 preloaded with 7,8,9; out_ready low for 5 cycles on the second word -> out stream is 7,8,9 with out_data stable while stalled; then done=1.
- TIMEOUT=100 and core_end never rises -> timeout_err=1 after 100 RUN cycles, busy=0; a following cmd_go restarts the job cleanly.
- RESET asserted in the middle of LOAD -> all outputs are 0 immediately (asynchronously) and state is IDLE; load_len=0 and res_len=0 job -> KICK, RUN, DONE with no writes or reads.

Source files
------------

// File: rtl/dmem_host_sequencer.sv
// Host-side job sequencer: loads operands into data memory, kicks the core,
// waits for END, then streams the result region back out.
module dmem_host_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              cmd_go,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [ADDR_W-1:0] res_base,
  input  logic [ADDR_W-1:0] res_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] current_addr,
  output logic              write_from_tb,
  output logic [DATA_W-1:0] mem_data,
  output logic [1:0]        addr_mux_select,
  output logic [ADDR_W-1:0] ar_in,
  output logic              START,
  input  logic              core_end,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_KICK, S_RUN, S_RD_ADDR, S_RD_CAP, S_OUT, S_DONE, S_ERR
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] load_base_reg;
  logic [ADDR_W-1:0] load_len_reg;
  logic [ADDR_W-1:0] res_base_reg;
  logic [ADDR_W-1:0] res_len_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] ridx_reg;
  logic [CNT_W-1:0]  cyc_reg;
  logic              end_q_reg;
  logic              core_end_rise;

  // Only a fresh rising edge of END counts; a level left high by a prior job is ignored.
  assign core_end_rise = core_end && !end_q_reg;

  // The write port follows the handshake combinationally so each accepted word lands that cycle.
  assign write_from_tb = in_ready && in_valid;
  assign current_addr  = in_ready ? load_base_reg + idx_reg : '0;
  assign mem_data      = in_ready ? in_data : '0;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_reg       <= S_IDLE;
      load_base_reg   <= '0;
      load_len_reg    <= '0;
      res_base_reg    <= '0;
      res_len_reg     <= '0;
      idx_reg         <= '0;
      ridx_reg        <= '0;
      cyc_reg         <= '0;
      end_q_reg       <= 1'b0;
      in_ready        <= 1'b0;
      addr_mux_select <= 2'b00;
      ar_in           <= '0;
      START           <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      START     <= 1'b0;
      end_q_reg <= core_end;
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (cmd_go) begin
            load_base_reg <= load_base;
            load_len_reg  <= load_len;
            res_base_reg  <= res_base;
            res_len_reg   <= res_len;
            idx_reg       <= '0;
            ridx_reg      <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            if (load_len == '0) begin
              state_reg <= S_KICK;
              START     <= 1'b1;
            end else begin
              state_reg       <= S_LOAD;
              in_ready        <= 1'b1;
              addr_mux_select <= 2'b01;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            idx_reg <= idx_reg + ADDR_W'(1);
            if (idx_reg == load_len_reg - ADDR_W'(1)) begin
              state_reg       <= S_KICK;
              START           <= 1'b1;
              in_ready        <= 1'b0;
              addr_mux_select <= 2'b00;
            end
          end
        end
        S_KICK: begin
          cyc_reg   <= '0;
          state_reg <= S_RUN;
        end
        S_RUN: begin
          // The edge is tested first so it wins over a simultaneous timeout.
          if (core_end_rise) begin
            if (res_len_reg == '0) begin
              state_reg <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg       <= S_RD_ADDR;
              addr_mux_select <= 2'b10;
              ar_in           <= res_base_reg + ridx_reg;
            end
          end else if (cyc_reg == CNT_W'(TIMEOUT - 1)) begin
            state_reg   <= S_ERR;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cyc_reg <= cyc_reg + CNT_W'(1);
          end
        end
        S_RD_ADDR: begin
          state_reg <= S_RD_CAP;
        end
        S_RD_CAP: begin
          out_data        <= rd_data;
          out_valid       <= 1'b1;
          addr_mux_select <= 2'b00;
          ar_in           <= '0;
          state_reg       <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ridx_reg  <= ridx_reg + ADDR_W'(1);
            if (ridx_reg == res_len_reg - ADDR_W'(1)) begin
              state_reg <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg       <= S_RD_ADDR;
              addr_mux_select <= 2'b10;
              ar_in           <= res_base_reg + ridx_reg + ADDR_W'(1);
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_host_sequencer.sv
// Randomized bench for dmem_host_sequencer: emulates data memory and the core's END,
// and checks every cycle against a job-level model of loads, kick, run and readback.
module tb_dmem_host_sequencer;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          RESET;
  logic          cmd_go;
  logic [AW-1:0] load_base, load_len, res_base, res_len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] current_addr;
  logic          write_from_tb;
  logic [DW-1:0] mem_data;
  logic [1:0]    addr_mux_select;
  logic [AW-1:0] ar_in;
  logic          START;
  logic          core_end;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy, done, timeout_err;

  always #5 clk = ~clk;

  dmem_host_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .RESET(RESET), .cmd_go(cmd_go),
    .load_base(load_base), .load_len(load_len), .res_base(res_base), .res_len(res_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .current_addr(current_addr), .write_from_tb(write_from_tb), .mem_data(mem_data),
    .addr_mux_select(addr_mux_select), .ar_in(ar_in), .START(START),
    .core_end(core_end), .rd_data(rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // Environment memory (what the top level holds) and the reference image of it.
  logic [DW-1:0] env_mem [0:65535];
  logic [DW-1:0] exp_mem [0:65535];
  logic [DW-1:0] rd_next;
  logic [DW-1:0] load_q[$];
  logic [DW-1:0] pre_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge clk) rd_data <= rd_next;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_job(input logic [15:0] lb, input logic [15:0] ll,
                         input logic [15:0] rb, input logic [15:0] rl,
                         input int vprob, input int rprob, input int end_delay,
                         input bit stale, input int stall_w);
    logic [DW-1:0] ldata[$];
    logic [DW-1:0] prev_data;
    logic [1:0]    exp_mux;
    int  cycle, wr_idx, out_idx, start_cycle, kick_exp, edge_cycle, rd_start;
    int  last_hs, stall_left, n_start, exp_end;
    bit  to_exp, hs, prev_valid, prev_hs, finished, in_ld, rd_act;
    to_exp = (end_delay == 0 || end_delay > TO);
    for (int i = 0; i < int'(rl); i++) begin
      logic [DW-1:0] v;
      v = (i < pre_q.size()) ? pre_q[i] : DW'($urandom);
      env_mem[16'(rb + i)] = v;
      exp_mem[16'(rb + i)] = v;
    end
    for (int i = 0; i < int'(ll); i++) begin
      logic [DW-1:0] d;
      d = (i < load_q.size()) ? load_q[i] : DW'($urandom);
      ldata.push_back(d);
      exp_mem[16'(lb + i)] = d;
    end
    load_q.delete();
    pre_q.delete();
    kick_exp = (ll == 0) ? 1 : -1;
    start_cycle = -1; edge_cycle = -1; rd_start = -1; last_hs = -1;
    stall_left = 5; n_start = 0; wr_idx = 0; out_idx = 0;
    prev_valid = 0; prev_hs = 0; prev_data = '0; finished = 0; cycle = 0;
    while (!finished) begin
      @(negedge clk);
      if (cycle == 0) begin
        cmd_go = 1'b1; load_base = lb; load_len = ll; res_base = rb; res_len = rl;
      end else begin
        // Stray go pulses and changing fields while busy must have no effect.
        cmd_go    = busy && ($urandom_range(0, 7) == 0);
        load_base = AW'($urandom); load_len = AW'($urandom);
        res_base  = AW'($urandom); res_len  = AW'($urandom);
      end
      in_valid = (vprob >= 100) ? 1'b1 : (vprob == 0) ? cycle[0] : ($urandom_range(0, 99) < vprob);
      in_data  = (wr_idx < int'(ll)) ? ldata[wr_idx] : DW'($urandom);
      if (out_valid && out_idx == stall_w && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(0, 99) < rprob);
      end
      if (start_cycle < 0) core_end = stale;
      else if (!to_exp && cycle >= start_cycle + end_delay) core_end = 1'b1;
      else if (stale && cycle < start_cycle + 5) core_end = 1'b1;
      else core_end = 1'b0;
      if (start_cycle >= 0 && !to_exp && cycle == start_cycle + end_delay) begin
        edge_cycle = cycle;
        rd_start   = cycle + 1;
      end
      #1;
      in_ld   = (cycle >= 1) && (wr_idx < int'(ll));
      rd_act  = (edge_cycle >= 0) && (out_idx < int'(rl));
      exp_mux = in_ld ? 2'b01 : (rd_act && (cycle == rd_start || cycle == rd_start + 1)) ? 2'b10 : 2'b00;
      chk("in_ready", in_ready, in_ld);
      chk("wr_en", write_from_tb, in_ld && in_valid);
      chk("mux", addr_mux_select, exp_mux);
      chk("start", START, cycle == kick_exp);
      chk("out_valid", out_valid, rd_act && cycle >= rd_start + 2);
      if (exp_mux == 2'b10) chk("ar_in", ar_in, 16'(rb + out_idx));
      rd_next = (addr_mux_select == 2'b10) ? env_mem[ar_in] : DW'($urandom);
      if (write_from_tb && wr_idx < int'(ll)) begin
        chk("wr_addr", current_addr, 16'(lb + wr_idx));
        chk("wr_data", mem_data, ldata[wr_idx]);
        env_mem[current_addr] = mem_data;
        wr_idx++;
        if (wr_idx == int'(ll)) kick_exp = cycle + 1;
      end
      if (START) begin
        n_start++;
        if (start_cycle < 0) start_cycle = cycle;
      end
      if (prev_valid && !prev_hs && out_valid) chk("out_hold", out_data, prev_data);
      hs = out_valid && out_ready;
      if (hs && out_idx < int'(rl)) begin
        chk("out_data", out_data, exp_mem[16'(rb + out_idx)]);
        out_idx++;
        last_hs  = cycle;
        rd_start = cycle + 1;
      end
      prev_valid = out_valid; prev_hs = hs; prev_data = out_data;
      if (cycle == 1) chk("busy_go", busy, 1);
      if (cycle >= 1 && (done || timeout_err)) begin
        if (to_exp) exp_end = start_cycle + TO + 1;
        else if (rl == 0) exp_end = edge_cycle + 1;
        else exp_end = (out_idx == int'(rl)) ? last_hs + 1 : -1;
        chk("end_cycle", cycle, exp_end);
        chk("done", done, !to_exp);
        chk("timeout_err", timeout_err, to_exp);
        chk("busy_end", busy, 0);
        chk("n_start", n_start, 1);
        chk("n_writes", wr_idx, ll);
        chk("n_reads", out_idx, to_exp ? 0 : rl);
        $display("job lb=%04h ll=%0d rb=%04h rl=%0d delay=%0d stale=%0d -> %s at cycle %0d, %0d writes, %0d reads",
                 lb, ll, rb, rl, end_delay, stale, done ? "done" : "err", cycle, wr_idx, out_idx);
        finished = 1;
      end
      cycle++;
      if (!finished && cycle > 3000) begin
        chk("job_bound", 0, 1);
        finished = 1;
      end
    end
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    cmd_go = 1'b1; load_base = 16'h0100; load_len = 16'd8; res_base = '0; res_len = '0;
    in_valid = 1'b0;
    @(negedge clk);
    cmd_go = 1'b0; in_valid = 1'b1; in_data = 16'h5a5a;
    #1;
    chk("ld_ready", in_ready, 1);
    chk("ld_wr", write_from_tb, 1);
    @(negedge clk);
    #1 RESET = 1'b0;
    #1;
    chk("rst_wr", write_from_tb, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_addr", current_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_mux", addr_mux_select, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rest", {START, out_valid, done, timeout_err, ar_in, out_data}, 0);
    $display("reset asserted mid-load: busy=%0d in_ready=%0d write=%0d", busy, in_ready, write_from_tb);
    @(negedge clk);
    RESET = 1'b1; in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; cmd_go = 1'b0; load_base = '0; load_len = '0; res_base = '0; res_len = '0;
    in_valid = 1'b0; in_data = '0; core_end = 1'b0; out_ready = 1'b0; rd_next = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_outs", {in_ready, write_from_tb, START, out_valid, done, timeout_err, addr_mux_select}, 0);
    chk("init_addr", {current_addr, ar_in, mem_data, out_data}, 0);
    @(negedge clk);
    RESET = 1'b1;

    load_q = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    pre_q  = '{16'd7, 16'd8, 16'd9};
    run_job(16'h0010, 16'd4, 16'h0040, 16'd3, 100, 100, 10, 1'b0, 1);
    run_job(16'h0010, 16'd4, 16'h0080, 16'd2, 0, 70, 15, 1'b0, -1);
    run_job(16'h0200, 16'd3, 16'h0200, 16'd3, 80, 100, 20, 1'b1, -1);
    run_job(16'h0300, 16'd2, 16'h0300, 16'd2, 100, 100, 0, 1'b0, -1);
    run_job(16'h0300, 16'd2, 16'h0300, 16'd2, 100, 100, TO, 1'b0, -1);
    run_job(16'hFFFD, 16'd6, 16'hFFFE, 16'd4, 60, 60, 8, 1'b0, 2);
    reset_mid_load();
    run_job(16'h0000, 16'd0, 16'h0000, 16'd0, 100, 100, 5, 1'b0, -1);
    for (int j = 0; j < 8; j++) begin
      run_job(16'($urandom), 16'($urandom_range(0, 12)), 16'($urandom), 16'($urandom_range(0, 6)),
              int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
              int'($urandom_range(6, 40)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
